// File: rtl/exe_muldiv_if.sv
// Handshake/result bundle between the EX stage and the iterative mul/div unit.
interface exe_muldiv_if;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [63:0] hilo_out;
    logic        exe_stall;
    logic        md_done;

    modport master (
        output md_start, md_op, src_a, src_b,
        input  hilo_out, exe_stall, md_done
    );

    modport slave (
        input  md_start, md_op, src_a, src_b,
        output hilo_out, exe_stall, md_done
    );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative MIPS32 multiply/divide unit: 32 iterations (one bit per cycle),
// fixed 33-cycle stall, result {HI,LO} registered on entry to DONE.
module exe_muldiv (
    input  logic          clk,
    input  logic          resetn,
    exe_muldiv_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_res;     // negate product / quotient
    logic        neg_rem;     // remainder takes dividend sign
    logic        div_zero;
    logic [31:0] raw_a;       // dividend as presented, for the divide-by-zero result
    logic [31:0] opnd;        // multiplicand (mul) or divisor (div) magnitude
    logic [31:0] acc_hi;      // partial product high half / partial remainder
    logic [31:0] acc_lo;      // multiplier bits / dividend bits shifting into quotient
    logic [63:0] hilo;

    // Launch-time operand conditioning: signed ops work on magnitudes.
    logic        is_signed;
    logic [31:0] mag_a, mag_b;
    assign is_signed = ~bus.md_op[0];
    assign mag_a     = (is_signed && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign mag_b     = (is_signed && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    // One shift-add multiply step: add multiplicand if the current multiplier bit is set.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, acc_lo[31:1]};

    // One restoring divide step: shift in the next dividend bit, subtract if it fits.
    logic [32:0] div_shift, div_sub;
    logic        div_ge;
    logic [31:0] rem_next, quo_next;
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift - {1'b0, opnd};
    assign rem_next  = div_ge ? div_sub[31:0] : div_shift[31:0];
    assign quo_next  = {acc_lo[30:0], div_ge};

    // Final sign fix-up, applied to the values produced by the last iteration.
    logic [63:0] mul_fix, div_fix;
    assign mul_fix = neg_res ? (64'd0 - mul_next) : mul_next;
    assign div_fix = div_zero ? {raw_a, 32'hFFFF_FFFF}
                   : {(neg_rem ? (32'd0 - rem_next) : rem_next),
                      (neg_res ? (32'd0 - quo_next) : quo_next)};

    // Sequencer and datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            raw_a    <= 32'd0;
            opnd     <= 32'd0;
            acc_hi   <= 32'd0;
            acc_lo   <= 32'd0;
            hilo     <= 64'd0;
        end else begin
            case (state)
                IDLE: if (bus.md_start) begin
                    state    <= BUSY;
                    cnt      <= 5'd0;
                    is_div   <= bus.md_op[1];
                    neg_res  <= is_signed & (bus.src_a[31] ^ bus.src_b[31]);
                    neg_rem  <= is_signed & bus.src_a[31];
                    div_zero <= bus.md_op[1] & (bus.src_b == 32'd0);
                    raw_a    <= bus.src_a;
                    acc_hi   <= 32'd0;
                    if (bus.md_op[1]) begin
                        opnd   <= mag_b;
                        acc_lo <= mag_a;
                    end else begin
                        opnd   <= mag_a;
                        acc_lo <= mag_b;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc_hi <= rem_next;
                        acc_lo <= quo_next;
                    end else begin
                        acc_hi <= mul_next[63:32];
                        acc_lo <= mul_next[31:0];
                    end
                    if (cnt == 5'd31) begin
                        state <= DONE;
                        hilo  <= is_div ? div_fix : mul_fix;
                    end
                end
                default: state <= IDLE;  // DONE never relaunches, even with md_start high
            endcase
        end
    end

    assign bus.hilo_out  = hilo;
    assign bus.md_done   = (state == DONE);
    assign bus.exe_stall = (state == BUSY) | ((state == IDLE) & bus.md_start);
endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: vector table plus reset/back-to-back sequences,
// results checked through an expected-value queue popped on md_done.
module tb_exe_muldiv;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    exe_muldiv_if bus ();

    exe_muldiv dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model using plain language arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = 32'($signed(a) / $signed(b));
                r = 32'($signed(a) % $signed(b));
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard: every md_done pops one expected result.
    always @(negedge clk) begin
        if (resetn && bus.md_done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("spurious_done", bus.hilo_out, 64'hx);
            else chk("hilo", bus.hilo_out, exp_q.pop_front());
        end
    end

    // Launch an op at the current cycle T (called just after a posedge), hold md_start
    // through DONE, check stall/done timing, return just after the edge ending DONE.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int cyc = 0;
        int stalls = 0;
        bus.md_start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        exp_q.push_back(exp);
        forever begin
            @(negedge clk);
            if (bus.md_done) break;
            if (bus.exe_stall) stalls++;
            cyc++;
            if (cyc > 100) begin
                chk({name, "_timeout"}, 64'(cyc), 64'd33);
                void'(exp_q.pop_back());
                break;
            end
            @(posedge clk); #1;
            bus.src_a = $urandom();  // ignored while BUSY
            bus.md_op = 2'($urandom());
        end
        chk({name, "_latency"}, 64'(cyc), 64'd33);
        chk({name, "_stall_cycles"}, 64'(stalls), 64'd33);
        chk({name, "_stall_at_done"}, 64'(bus.exe_stall), 64'd0);
        @(posedge clk); #1;
        bus.md_start = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{"mult_neg",    2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2]  = '{"mult_min",    2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3]  = '{"divu_100_7",  2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E};
        vecs[4]  = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
        vecs[5]  = '{"div_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[6]  = '{"divu_by0",    2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF};
        vecs[7]  = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[8]  = '{"div_neg_by0", 2'b10, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF};
        vecs[9]  = '{"mult_zero",   2'b00, 32'd0,         32'hFFFF_FFF7, 64'h0};
        vecs[10] = '{"div_m8_m3",   2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFF_FFFE_0000_0002};
        vecs[11] = '{"multu_2_5",   2'b01, 32'd2,         32'd5,         64'h0000_0000_0000_000A};

        bus.md_start = 1'b0;
        bus.md_op = 2'b00;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hilo", bus.hilo_out, 64'h0);
        chk("reset_done", 64'(bus.md_done), 64'd0);
        chk("reset_stall", 64'(bus.exe_stall), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Consecutive calls are back-to-back: each new op is presented the cycle after DONE.
        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        chk("done_count_table", 64'(done_cnt), 64'd12);

        // Reset mid-operation: MULTU 3*4 abandoned at T+10.
        @(posedge clk); #1;
        bus.md_start = 1'b1; bus.md_op = 2'b01; bus.src_a = 32'd3; bus.src_b = 32'd4;
        repeat (10) begin @(posedge clk); #1; end
        resetn = 1'b0;
        bus.md_start = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_stall", 64'(bus.exe_stall), 64'd0);
        chk("rst_mid_done", 64'(bus.md_done), 64'd0);
        chk("rst_mid_hilo", bus.hilo_out, 64'h0);
        resetn = 1'b1;
        @(posedge clk); #1;
        run_op("divu_9_3", 2'b11, 32'd9, 32'd3, 64'h0000_0000_0000_0003);
        chk("done_count_reset", 64'(done_cnt), 64'd13);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 4; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'(i);
            a = $urandom();
            b = (i >= 2) ? 32'($urandom_range(1, 65535)) : $urandom();
            run_op("rand", op, a, b, model(op, a, b));
        end

        repeat (3) @(posedge clk);
        chk("done_count_total", 64'(done_cnt), 64'd17);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Iterative multiply/divide unit in the execute stage. It produces the 64-bit {HI,LO} result that the EX/MEM register captures as hilo_out. While an operation is running it drives exe_stall, which holds the instruction in EX and inserts a bubble into EX/MEM. It supports MULT, MULTU, DIV and DIVU with a fixed, data-independent latency.

Parameters:
none; all widths are fixed at MIPS32 (32-bit operands, 64-bit result, 32 iterations).

Ports:
clk        input   1   clock; all state updates on posedge
resetn     input   1   synchronous reset, active-low
md_start   input   1   EX instruction is mul/div; held high for as long as the instruction sits in EX
md_op      input   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a      input   32  rs value (multiplicand / dividend)
src_b      input   32  rt value (multiplier / divisor)
hilo_out   output  64  {HI,LO}; for DIV: HI = remainder, LO = quotient
exe_stall  output  1   hold the pipeline; EX/MEM loads a bubble
md_done    output  1   result valid this cycle, one-cycle pulse

Behaviour:
- Reset (resetn==0 at posedge):
  - state goes to IDLE.
  - hilo_out = 64'h0, md_done = 0, iteration counter = 0.
  - exe_stall = 0 from the following cycle.
  - Reset mid-operation abandons the operation; no partial result is ever written to hilo_out.
- States: IDLE, BUSY, DONE.
- IDLE:
  - exe_stall = md_start (combinational).
  - On md_start=1: latch op, operand magnitudes (signed ops take |x|; unsigned ops use raw values) and the result-sign flags. Clear the counter and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - exe_stall = 1.
  - One iteration per cycle: multiply is shift-add, one multiplier bit per cycle; divide is restoring, one quotient bit per cycle.
  - The counter increments each cycle. After the 32nd iteration, go to DONE.
  - md_start, md_op, src_a and src_b are ignored while BUSY.
- DONE:
  - exe_stall = 0 and md_done = 1.
  - hilo_out is registered on entry to DONE and holds until the next DONE.
  - md_start is still high in this cycle (same instruction) and must NOT relaunch. Always return to IDLE.
- Latency: if md_start is first seen in IDLE at cycle T, then BUSY occupies T+1..T+32 and DONE is T+33.
  - exe_stall is high for exactly 33 cycles (T..T+32).
  - EX/MEM captures hilo_out at the edge that ends T+33.
- Back-to-back: a new mul/div instruction arriving at T+34 launches immediately from IDLE. There is no dead cycle beyond DONE.
- Sign fix-up (signed ops only):
  - Product is negated (64-bit two's complement) if operand signs differ.
  - Quotient is negated if dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU, src_b==0):
  - Same 33-cycle latency.
  - Result is forced to HI = src_a as latched, LO = 32'hFFFF_FFFF. No sign fix-up is applied.
- Signed overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF: result HI = 0, LO = 32'h8000_0000.
- Zero operands follow normal iteration; the result is 0 and latency is unchanged.

Test Plan:
1. MULTU src_a=src_b=32'hFFFF_FFFF, start at T.
   -> exe_stall high T..T+32, low at T+33; md_done pulses at T+33; hilo_out = 64'hFFFF_FFFE_0000_0001.
2. MULT src_a=-3, src_b=7.
   -> hilo_out = 64'hFFFF_FFFF_FFFF_FFEB.
   MULT 32'h8000_0000 * 32'h8000_0000.
   -> hilo_out = 64'h4000_0000_0000_0000.
3. DIVU 100/7.
   -> HI=2, LO=14.
   DIV -7/2.
   -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
   DIV 7/-2.
   -> LO=32'hFFFF_FFFD, HI=1.
4. DIVU 5/0.
   -> HI=5, LO=32'hFFFF_FFFF after 33 stall cycles.
   DIV 32'h8000_0000/32'hFFFF_FFFF.
   -> HI=0, LO=32'h8000_0000.
5. Launch MULTU 3*4, assert resetn=0 at T+10.
   -> from T+11: exe_stall=0, md_done=0, hilo_out=0.
   Then launch DIVU 9/3 with md_start held.
   -> DONE 33 cycles later with HI=0, LO=3; the earlier MULTU result never appears.
6. md_start held through DONE, then a second MULTU 2*5 presented at T+34.
   -> exactly one md_done for the first op; the second launches at T+34 and completes at T+67 with hilo_out=64'hA.
